// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the minimal CPU's RAM interface.
//
// Holds DEPTH x DATA_W words of storage, all of it cleared by reset. After reset, a boot
// loader fills memory from a byte stream while the processor is held in reset. It then
// passes through a one-cycle release state and runs the CPU. While the CPU runs, it gets
// a combinational read port and a registered write port.
//
// Optional feature macro: STORE_BYPASS_EN
//   defined   - in RUN, a read and a write to the same address in the same cycle return
//               the write data (write-first forwarding).
//   undefined - the read returns the old contents (read-first).
//
// Ports:
//   clk            in   system clock, all state updates on posedge
//   rst            in   asynchronous active-low reset
//   load_valid     in   loader byte valid
//   load_data      in   loader byte
//   load_last      in   final loader byte marker (qualified by load_valid)
//   load_ready     out  loader may transfer (high only in LOAD)
//   reload         in   single-cycle request to re-enter LOAD from RUN
//   cpu_rst        out  active-low processor reset, high only in RUN
//   ram_read_e     in   CPU read enable
//   ram_addr_read  in   CPU read address
//   ram_data_read  out  CPU read data (combinational, zero when not reading in RUN)
//   ram_write_e    in   CPU write enable
//   ram_addr_write in   CPU write address
//   ram_data_write in   CPU write data
//   wr_count       out  saturating count of CPU writes since the last load

module ram_responder #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic              reload,
   output logic              cpu_rst,
   input  logic              ram_read_e,
   input  logic [ADDR_W-1:0] ram_addr_read,
   output logic [DATA_W-1:0] ram_data_read,
   input  logic              ram_write_e,
   input  logic [ADDR_W-1:0] ram_addr_write,
   input  logic [DATA_W-1:0] ram_data_write,
   output logic [7:0]        wr_count
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      StLoad    = 2'd0,
      StRelease = 2'd1,
      StRun     = 2'd2
   } state_e;

   state_e            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [7:0]        r_wr_count;
   logic              r_load_ready;
   logic              r_cpu_rst;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_load_xfer;
   logic [DATA_W-1:0] w_rd_data;

   assign w_load_xfer = load_valid & r_load_ready;

   // Single FSM block: state, pointer, storage, write counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= StLoad;
         r_ptr        <= '0;
         r_wr_count   <= '0;
         r_load_ready <= 1'b1;
         r_cpu_rst    <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         unique case (r_state)
            StLoad: begin
               if (w_load_xfer) begin
                  r_mem[r_ptr] <= load_data;
                  // Leaving on the last slot also wraps the pointer back to 0.
                  if (load_last || (r_ptr == LastAddr)) begin
                     r_ptr        <= '0;
                     r_state      <= StRelease;
                     r_load_ready <= 1'b0;
                  end else begin
                     r_ptr <= r_ptr + ADDR_W'(1);
                  end
               end
            end
            StRelease: begin
               r_wr_count <= '0;
               r_state    <= StRun;
               r_cpu_rst  <= 1'b1;
            end
            StRun: begin
               if (ram_write_e) begin
                  r_mem[ram_addr_write] <= ram_data_write;
                  if (r_wr_count != 8'hFF) begin
                     r_wr_count <= r_wr_count + 8'd1;
                  end
               end
               // A write in the reload cycle still commits above; memory is kept.
               if (reload) begin
                  r_state      <= StLoad;
                  r_ptr        <= '0;
                  r_load_ready <= 1'b1;
                  r_cpu_rst    <= 1'b0;
               end
            end
            default: begin
               r_state      <= StLoad;
               r_ptr        <= '0;
               r_load_ready <= 1'b1;
               r_cpu_rst    <= 1'b0;
            end
         endcase
      end
   end

   // Read port is combinational so the CPU may sample on either clock edge.
   always_comb begin
      w_rd_data = '0;
      if ((r_state == StRun) && ram_read_e) begin
         w_rd_data = r_mem[ram_addr_read];
`ifdef STORE_BYPASS_EN
         if (ram_write_e && (ram_addr_write == ram_addr_read)) begin
            w_rd_data = ram_data_write;
         end
`endif
      end
   end

   assign ram_data_read = w_rd_data;
   assign load_ready    = r_load_ready;
   assign cpu_rst       = r_cpu_rst;
   assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus randomized traffic,
// compared against a behavioural model of the loader / release / run protocol.

module tb_ram_responder;

   localparam int PhLoad = 0;
   localparam int PhRel  = 1;
   localparam int PhRun  = 2;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       reload;
   logic       cpu_rst;
   logic       ram_read_e;
   logic [3:0] ram_addr_read;
   logic [7:0] ram_data_read;
   logic       ram_write_e;
   logic [3:0] ram_addr_write;
   logic [7:0] ram_data_write;
   logic [7:0] wr_count;

   ram_responder #(
      .ADDR_W(4),
      .DATA_W(8),
      .DEPTH (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_valid    (load_valid),
      .load_data     (load_data),
      .load_last     (load_last),
      .load_ready    (load_ready),
      .reload        (reload),
      .cpu_rst       (cpu_rst),
      .ram_read_e    (ram_read_e),
      .ram_addr_read (ram_addr_read),
      .ram_data_read (ram_data_read),
      .ram_write_e   (ram_write_e),
      .ram_addr_write(ram_addr_write),
      .ram_data_write(ram_data_write),
      .wr_count      (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model.
   int m_mem [16];
   int m_phase;
   int m_ptr;
   int m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      m_phase = PhLoad;
      m_ptr   = 0;
      m_count = 0;
   endfunction

   function automatic int exp_read();
      int v;
      v = 0;
      if (m_phase == PhRun && ram_read_e) begin
         v = m_mem[ram_addr_read];
`ifdef STORE_BYPASS_EN
         if (ram_write_e && ram_addr_write == ram_addr_read) v = ram_data_write;
`endif
      end
      return v;
   endfunction

   function automatic void model_edge();
      case (m_phase)
         PhLoad: begin
            if (load_valid) begin
               m_mem[m_ptr] = load_data;
               if (load_last || m_ptr == 15) begin
                  m_ptr   = 0;
                  m_phase = PhRel;
               end else begin
                  m_ptr = m_ptr + 1;
               end
            end
         end
         PhRel: begin
            m_count = 0;
            m_phase = PhRun;
         end
         default: begin
            if (ram_write_e) begin
               m_mem[ram_addr_write] = ram_data_write;
               if (m_count < 255) m_count = m_count + 1;
            end
            if (reload) begin
               m_phase = PhLoad;
               m_ptr   = 0;
            end
         end
      endcase
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, ".load_ready"}, 32'(load_ready), 32'(m_phase == PhLoad));
      check({tag, ".cpu_rst"}, 32'(cpu_rst), 32'(m_phase == PhRun));
      check({tag, ".wr_count"}, 32'(wr_count), 32'(m_count));
   endtask

   // One clock cycle: apply inputs, check the combinational read, clock, check state.
   task automatic cyc(input bit lv, input int ld, input bit ll, input bit rl,
                      input bit re, input int ra, input bit we, input int wa, input int wd);
      load_valid     = lv;
      load_data      = 8'(ld);
      load_last      = ll;
      reload         = rl;
      ram_read_e     = re;
      ram_addr_read  = 4'(ra);
      ram_write_e    = we;
      ram_addr_write = 4'(wa);
      ram_data_write = 8'(wd);
      #1;
      check("rd", 32'(ram_data_read), 32'(exp_read()));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs("cyc");
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic load_byte(input int d, input bit last);
      cyc(1, d, last, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic read_at(input int a);
      cyc(0, 0, 0, 0, 1, a, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b0;
      load_valid = 0; load_data = 0; load_last = 0; reload = 0;
      ram_read_e = 0; ram_addr_read = 0; ram_write_e = 0; ram_addr_write = 0;
      ram_data_write = 0;
      model_reset();
      #12;
      check_outputs("reset");
      check("reset.load_ready_hi", 32'(load_ready), 32'd1);
      rst = 1'b1;

      // Three-byte load ending with load_last.
      load_byte(8'h11, 0);
      load_byte(8'h22, 0);
      load_byte(8'h33, 1);
      check("ld3.ready_low", 32'(load_ready), 32'd0);
      check("ld3.in_release", 32'(cpu_rst), 32'd0);
      idle();
      check("ld3.cpu_rst_hi", 32'(cpu_rst), 32'd1);
      for (int a = 0; a < 4; a++) read_at(a);

      // Reload with 16 bytes, no load_last: auto-exit after the 16th.
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("rl.cpu_rst_low", 32'(cpu_rst), 32'd0);
      for (int i = 0; i < 16; i++) load_byte(i, 0);
      check("ld16.auto_exit", 32'(load_ready), 32'd0);
      idle();
      read_at(15);
      cyc(0, 0, 0, 0, 0, 15, 0, 0, 0);

      // Same-cycle read and write to address 7.
      cyc(0, 0, 0, 0, 1, 7, 1, 7, 8'hA5);
      read_at(7);
      check("wr1.count", 32'(wr_count), 32'd1);

      // Saturating write counter.
      for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 0, 1, i % 16, i);
      check("sat.count", 32'(wr_count), 32'd255);
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("rl2.ready", 32'(load_ready), 32'd1);
      // Write to address 3 during LOAD must be ignored.
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 8'hFF);
      load_byte(8'h5C, 1);
      idle();
      check("rl2.count_clr", 32'(wr_count), 32'd0);
      for (int a = 0; a < 16; a++) read_at(a);

      // Reset in the middle of a load.
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) load_byte(8'hE0 + i, 0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst");
      #2;
      rst = 1'b1;
      load_byte(8'h77, 0);
      load_byte(8'h88, 1);
      idle();
      for (int a = 0; a < 16; a++) read_at(a);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         if (m_phase == PhLoad) begin
            cyc($urandom_range(0, 1), $urandom_range(0, 255), ($urandom_range(0, 7) == 0), 0,
                $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1),
                $urandom_range(0, 15), $urandom_range(0, 255));
         end else begin
            cyc($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                ($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 15),
                $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
